// File: rtl/fpu_issue_ctl_if.sv
// IU <-> issue controller <-> FPU microcode sequencer signal bundle.
// The controller connects through the slave modport; the IU/sequencer side uses master.
interface fpu_issue_ctl_if #(
    parameter int PW = 1
);
    logic          iu_op_valid;
    logic [7:0]    iu_opcode;
    logic          iu_op_ready;
    logic          iu_kill;
    logic          fpuhold;
    logic          cyc0_rdy_p;
    logic          erop;
    logic [7:0]    nx_opcode;
    logic          nx_fpop_valid;
    logic          nx_opcode_look;
    logic          fpkill;
    logic          fpu_busy;
    logic          op_done;
    logic          unimpl_trap;
    logic [PW:0]   occupancy;

    modport master (
        output iu_op_valid, iu_opcode, iu_kill, fpuhold, cyc0_rdy_p, erop,
        input  iu_op_ready, nx_opcode, nx_fpop_valid, nx_opcode_look, fpkill,
               fpu_busy, op_done, unimpl_trap, occupancy
    );

    modport slave (
        input  iu_op_valid, iu_opcode, iu_kill, fpuhold, cyc0_rdy_p, erop,
        output iu_op_ready, nx_opcode, nx_fpop_valid, nx_opcode_look, fpkill,
               fpu_busy, op_done, unimpl_trap, occupancy
    );
endinterface

// File: rtl/fpu_issue_ctl.sv
// FP opcode issue controller: FIFO from the IU, one-at-a-time issue to the microcode sequencer.
// Optional watchdog on the RUN wait is compiled in with `define FPU_ISSUE_WDOG_EN.
module fpu_issue_ctl #(
    parameter int DEPTH = 2,
    parameter int PW    = 1
) (
    input  logic clk,
    input  logic reset_l,
    fpu_issue_ctl_if.slave bus
`ifdef FPU_ISSUE_WDOG_EN
    ,
    output logic wdog_err
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, CHECK, RUN} state_t;

    localparam logic [PW:0]   OCC_FULL = DEPTH;
    localparam logic [PW:0]   OCC_ONE  = 1;
    localparam logic [PW-1:0] PTR_ONE  = 1;

    state_t        state, state_nxt;
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   occ, occ_nxt;
    logic          push, pop;
    logic          done_nxt, trap_nxt;
    logic          op_done_q, trap_q;
    logic          wdog_fire;

    assign bus.iu_op_ready = (occ != OCC_FULL) & !bus.iu_kill;
    assign push            = bus.iu_op_valid & bus.iu_op_ready;

    always_comb begin
        occ_nxt = occ;
        if (push && !pop)
            occ_nxt = occ + OCC_ONE;
        else if (pop && !push)
            occ_nxt = occ - OCC_ONE;
    end

`ifdef FPU_ISSUE_WDOG_EN
    localparam logic [9:0] WDOG_LAST = 10'd1022;
    logic [9:0] wdog_cnt;
    logic       wdog_kill_q;
`endif

    // Kill overrides everything; hold freezes state, pops and pulses but not pushes.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        done_nxt  = 1'b0;
        trap_nxt  = 1'b0;
        wdog_fire = 1'b0;
        if (bus.iu_kill) begin
            state_nxt = IDLE;
        end else if (!bus.fpuhold) begin
            case (state)
                IDLE:  if (occ != '0) state_nxt = ISSUE;
                ISSUE: state_nxt = CHECK;
                CHECK: begin
                    pop = 1'b1;
                    if (bus.cyc0_rdy_p) begin
                        state_nxt = RUN;
                    end else begin
                        trap_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                RUN: begin
                    if (bus.erop) begin
                        done_nxt = 1'b1;
                        // RUN never pops, so a same-cycle push alone decides back-to-back issue.
                        state_nxt = ((occ != '0) || push) ? ISSUE : IDLE;
                    end
`ifdef FPU_ISSUE_WDOG_EN
                    else if (wdog_cnt == WDOG_LAST) begin
                        wdog_fire = 1'b1;
                        state_nxt = IDLE;
                    end
`endif
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            op_done_q <= 1'b0;
            trap_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            op_done_q <= done_nxt;
            trap_q    <= trap_nxt;
            if (bus.iu_kill) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                occ    <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_ONE;
                if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
                occ <= occ_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.iu_opcode;
    end

`ifdef FPU_ISSUE_WDOG_EN
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            wdog_cnt    <= '0;
            wdog_kill_q <= 1'b0;
            wdog_err    <= 1'b0;
        end else begin
            wdog_kill_q <= wdog_fire;
            if (wdog_fire) wdog_err <= 1'b1;
            if (state != RUN)
                wdog_cnt <= '0;
            else if (!bus.fpuhold && !bus.iu_kill)
                wdog_cnt <= wdog_cnt + 10'd1;
        end
    end
    assign bus.fpkill = bus.iu_kill | wdog_kill_q;
`else
    assign bus.fpkill = bus.iu_kill;
`endif

    assign bus.nx_opcode      = (state == ISSUE) ? mem[rd_ptr] : 8'h00;
    assign bus.nx_fpop_valid  = (state == ISSUE);
    assign bus.nx_opcode_look = (state == ISSUE);
    assign bus.fpu_busy       = (state != IDLE) | (occ != '0);
    assign bus.op_done        = op_done_q;
    assign bus.unimpl_trap    = trap_q;
    assign bus.occupancy      = occ;

endmodule
